// File: rtl/solar_pkg.sv
// -----------------------------------------------------------------------------
// solar_pkg
// Shared definitions for the solar controller sensor path.
//   - state_e        : sensor front-end FSM encoding
//   - CH_GH / CH_SOL : ADC channel codes (greenhouse / solar collector)
//   - ADC_W          : width of one ADC conversion result
//   - DEF_INIT_TEMP  : power-on greenhouse temperature, chosen so the
//                      downstream controller starts inside its idle band
//   - DEF_HYST       : margin (ADC counts) needed to declare solar hotter
// -----------------------------------------------------------------------------
package solar_pkg;

  localparam int ADC_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ_GH   = 3'd1,
    ST_WAIT_GH  = 3'd2,
    ST_REQ_SOL  = 3'd3,
    ST_WAIT_SOL = 3'd4,
    ST_UPDATE   = 3'd5
  } state_e;

  localparam logic CH_GH  = 1'b0;
  localparam logic CH_SOL = 1'b1;

  localparam int DEF_INIT_TEMP = 80;
  localparam int DEF_HYST      = 3;

endpackage

// File: rtl/solar_sensor_frontend_if.sv
// -----------------------------------------------------------------------------
// solar_sensor_frontend_if
// Bundles the ADC handshake and the published sensor results.
//   ADC side      : adc_start, adc_ch (out of front-end), adc_done, adc_data (in)
//   Consumer side : tsgh, ts_g_tsgh, valid, sensor_fault (out of front-end)
// Modports:
//   master : the sensor front-end
//   slave  : the ADC model / consumer
// -----------------------------------------------------------------------------
interface solar_sensor_frontend_if;
  import solar_pkg::*;

  logic             adc_start;
  logic             adc_ch;
  logic             adc_done;
  logic [ADC_W-1:0] adc_data;
  logic [ADC_W-1:0] tsgh;
  logic             ts_g_tsgh;
  logic             valid;
  logic             sensor_fault;

  modport master (
    output adc_start, adc_ch, tsgh, ts_g_tsgh, valid, sensor_fault,
    input  adc_done, adc_data
  );

  modport slave (
    input  adc_start, adc_ch, tsgh, ts_g_tsgh, valid, sensor_fault,
    output adc_done, adc_data
  );

endinterface

// File: rtl/sensor_avg_acc.sv
// -----------------------------------------------------------------------------
// sensor_avg_acc
// Per-channel block accumulator with truncating average.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears the sum)
//   add_i    : add data_i to the running sum this cycle
//   clr_i    : clear the running sum (wins over add_i)
//   data_i   : sample to accumulate
//   avg_o    : sum >> AVG_LOG2 (combinational view of the registered sum)
// The sum is DATA_W+AVG_LOG2 bits, enough for 2^AVG_LOG2 full-scale samples.
// -----------------------------------------------------------------------------
module sensor_avg_acc #(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] avg_o
);

  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + ACC_W'(data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Dropping the low AVG_LOG2 bits is the truncating divide.
  assign avg_o = acc_q[ACC_W-1:AVG_LOG2];

endmodule

// File: rtl/solar_sensor_frontend.sv
// -----------------------------------------------------------------------------
// solar_sensor_frontend
// Polls a shared ADC for the greenhouse and solar-collector channels, averages
// 2^AVG_LOG2 sample pairs per channel and publishes the averaged greenhouse
// temperature plus a hysteretic "solar hotter than greenhouse" flag.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : solar_sensor_frontend_if.master
//          adc_start/adc_ch/adc_done/adc_data : ADC start/done handshake
//          tsgh/ts_g_tsgh                     : registered results
//          valid                              : one-cycle pulse with new results
//          sensor_fault                       : ADC timeout indicator
// Optional feature (macro SENSOR_TIMEOUT_EN): abandon a conversion after
// TIMEOUT_CYC cycles in a WAIT state, discard the block and raise a sticky
// sensor_fault that the next successful update clears. Without the macro the
// WAIT states wait indefinitely and sensor_fault is tied low.
// -----------------------------------------------------------------------------
module solar_sensor_frontend
  import solar_pkg::*;
#(
  parameter int DATA_W        = ADC_W,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int HYST          = DEF_HYST,
  parameter int INIT_TEMP     = DEF_INIT_TEMP,
  parameter int TIMEOUT_CYC   = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  solar_sensor_frontend_if.master bus
);

  localparam int PER_W   = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int CNT_W   = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] SAMPLES = CNT_W'(1 << AVG_LOG2);

  // Elaboration-time parameter sanity.
  if (SAMPLE_PERIOD < 2) begin : g_bad_period
    $error("SAMPLE_PERIOD must be at least 2");
  end
  if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg
    $error("AVG_LOG2 must be in 0..4");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  // Set when idle, clear when sol <= gh; the set test is widened to 9 bits
  // so gh + HYST cannot wrap past 255.
  function automatic logic next_flag(input logic cur,
                                     input logic [DATA_W-1:0] gh,
                                     input logic [DATA_W-1:0] sol);
    logic [DATA_W:0] thr;
    thr = {1'b0, gh} + (DATA_W+1)'(HYST);
    if (!cur) begin
      return ({1'b0, sol} > thr);
    end
    return (sol > gh);
  endfunction

  state_e            state_q, state_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tsgh_q, tsgh_d;
  logic              flag_q, flag_d;
  logic              valid_q, valid_d;

  logic              gh_add, sol_add, acc_clr;
  logic [DATA_W-1:0] avg_gh, avg_sol;
  logic              adc_start, adc_ch;

`ifdef SENSOR_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              fault_q, fault_d;
`endif

  sensor_avg_acc #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_acc_gh (
    .clk    (clk),
    .rst    (rst),
    .add_i  (gh_add),
    .clr_i  (acc_clr),
    .data_i (bus.adc_data),
    .avg_o  (avg_gh)
  );

  sensor_avg_acc #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_acc_sol (
    .clk    (clk),
    .rst    (rst),
    .add_i  (sol_add),
    .clr_i  (acc_clr),
    .data_i (bus.adc_data),
    .avg_o  (avg_sol)
  );

  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    cnt_d     = cnt_q;
    tsgh_d    = tsgh_q;
    flag_d    = flag_q;
    valid_d   = 1'b0;
    gh_add    = 1'b0;
    sol_add   = 1'b0;
    acc_clr   = 1'b0;
    adc_start = 1'b0;
    adc_ch    = CH_GH;
`ifdef SENSOR_TIMEOUT_EN
    wcnt_d    = '0;
    fault_d   = fault_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (per_q == PER_W'(SAMPLE_PERIOD - 1)) begin
          per_d   = '0;
          state_d = ST_REQ_GH;
        end else begin
          per_d = per_q + PER_W'(1);
        end
      end

      ST_REQ_GH: begin
        adc_start = 1'b1;
        adc_ch    = CH_GH;
        state_d   = ST_WAIT_GH;
      end

      ST_WAIT_GH: begin
        adc_ch = CH_GH;
        if (bus.adc_done) begin
          gh_add  = 1'b1;
          state_d = ST_REQ_SOL;
        end
`ifdef SENSOR_TIMEOUT_EN
        else if (wcnt_q == WCNT_W'(TIMEOUT_CYC - 1)) begin
          fault_d = 1'b1;
          acc_clr = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
`endif
      end

      ST_REQ_SOL: begin
        adc_start = 1'b1;
        adc_ch    = CH_SOL;
        state_d   = ST_WAIT_SOL;
      end

      ST_WAIT_SOL: begin
        adc_ch = CH_SOL;
        if (bus.adc_done) begin
          sol_add = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q + CNT_W'(1) == SAMPLES) ? ST_UPDATE : ST_IDLE;
        end
`ifdef SENSOR_TIMEOUT_EN
        else if (wcnt_q == WCNT_W'(TIMEOUT_CYC - 1)) begin
          fault_d = 1'b1;
          acc_clr = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
`endif
      end

      ST_UPDATE: begin
        tsgh_d  = avg_gh;
        flag_d  = next_flag(flag_q, avg_gh, avg_sol);
        valid_d = 1'b1;
        acc_clr = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
`ifdef SENSOR_TIMEOUT_EN
        fault_d = 1'b0;
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      per_q   <= '0;
      cnt_q   <= '0;
      tsgh_q  <= DATA_W'(INIT_TEMP);
      flag_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      tsgh_q  <= tsgh_d;
      flag_q  <= flag_d;
      valid_q <= valid_d;
    end
  end

`ifdef SENSOR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      fault_q <= fault_d;
    end
  end

  assign bus.sensor_fault = fault_q;
`else
  assign bus.sensor_fault = 1'b0;
`endif

  assign bus.adc_start = adc_start;
  assign bus.adc_ch    = adc_ch;
  assign bus.tsgh      = tsgh_q;
  assign bus.ts_g_tsgh = flag_q;
  assign bus.valid     = valid_q;

endmodule

// File: doc/solar_sensor_frontend.md
Name: solar_sensor_frontend

Overview:
Upstream stage of the solar controller. Polls a shared 8-bit temperature ADC through a start/done handshake, alternating between the greenhouse channel and the solar-collector channel. Block-averages 2^AVG_LOG2 sample pairs per channel, then publishes the averaged greenhouse temperature (tsgh) and a hysteretic "solar hotter than greenhouse" flag (ts_g_tsgh). The controller consumes both outputs directly.

Parameters:
SAMPLE_PERIOD, 1000, clock cycles spent in IDLE between sample pairs (>=2)
AVG_LOG2, 2, log2 of samples per averaging block (0..4)
HYST, 3, margin in ADC counts required to set ts_g_tsgh
INIT_TEMP, 80, reset value of tsgh; keeps the downstream controller in its idle band
TIMEOUT_CYC, 255, maximum wait for adc_done (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
adc_start  out  1  one-cycle conversion request
adc_ch  out  1  channel select: 0 = greenhouse, 1 = solar; stable from adc_start until adc_done
adc_done  in  1  one-cycle pulse; adc_data is valid in the same cycle
adc_data  in  8  conversion result
tsgh  out  8  averaged greenhouse temperature, registered
ts_g_tsgh  out  1  solar > greenhouse flag with hysteresis, registered
valid  out  1  one-cycle pulse in the first cycle new tsgh/ts_g_tsgh values are visible
sensor_fault  out  1  ADC timeout indicator; tied to 0 without the optional feature

Behaviour:
- Reset values: tsgh = INIT_TEMP, ts_g_tsgh = 0, valid = 0, sensor_fault = 0, adc_start = 0, adc_ch = 0. Accumulators, sample count and period counter are 0. State is IDLE.
- FSM states: IDLE, REQ_GH, WAIT_GH, REQ_SOL, WAIT_SOL, UPDATE.
- IDLE: period counter increments each cycle. When it equals SAMPLE_PERIOD-1, clear it and go to REQ_GH. After reset, the first adc_start is asserted in cycle SAMPLE_PERIOD, counting the first post-reset cycle as 0.
- REQ_GH: adc_start = 1 and adc_ch = 0 for exactly one cycle, then WAIT_GH.
- WAIT_GH: on adc_done, acc_gh += adc_data, then REQ_SOL. adc_done outside a WAIT state is ignored.
- REQ_SOL / WAIT_SOL: same as the greenhouse pair with adc_ch = 1 and acc_sol. On adc_done, increment the sample count. If count == 2^AVG_LOG2, go to UPDATE; otherwise go to IDLE.
- UPDATE (one cycle): compute avg_gh = acc_gh >> AVG_LOG2 and avg_sol = acc_sol >> AVG_LOG2 (truncating). Accumulators are 8+AVG_LOG2 bits wide, so they cannot overflow.
  - tsgh <= avg_gh.
  - Flag rule: if ts_g_tsgh == 0 and avg_sol > avg_gh + HYST, set ts_g_tsgh. The comparison is done in 9 bits, with no wrap.
  - If ts_g_tsgh == 1 and avg_sol <= avg_gh, clear ts_g_tsgh. Otherwise hold.
  - valid <= 1 for one cycle, aligned with the new outputs.
  - Clear accumulators and count, then go to IDLE.
- Outputs hold between updates. adc_start is never asserted while a conversion is outstanding.
- rst in any state, including mid-handshake: return immediately to reset values. A late adc_done arriving in IDLE is ignored.

Optional Feature:
Macro SENSOR_TIMEOUT_EN.
- Defined: a wait counter runs in WAIT_GH and WAIT_SOL. If TIMEOUT_CYC cycles pass without adc_done:
  - set sensor_fault;
  - discard the current block (accumulators and count cleared);
  - go to IDLE with no valid pulse; tsgh and ts_g_tsgh hold.
  - sensor_fault is sticky until the next successful UPDATE, which clears it in the same cycle valid pulses.
- Undefined: WAIT states wait indefinitely; sensor_fault is constant 0.

Decomposition:
- Package solar_pkg holds:
  - FSM state encodings;
  - channel codes CH_GH = 0 and CH_SOL = 1;
  - default INIT_TEMP and HYST constants, shared with the controller's thresholds.
- One natural sub-module: sensor_avg_acc, a per-channel accumulate/clear/average unit, instantiated twice.

Test Plan:
1. Reset, SAMPLE_PERIOD = 8 -> tsgh = 80, ts_g_tsgh = 0, valid = 0; first adc_start with adc_ch = 0 at cycle 8 after reset release.
2. AVG_LOG2 = 2, gh = 100 and sol = 110 constant for 4 pairs -> exactly one valid pulse, tsgh = 100, ts_g_tsgh = 1.
3. gh samples 10, 11, 12, 13 -> tsgh = 11 (46 >> 2, truncation).
4. Hysteresis with flag = 1, gh = 100 (blocks in order):
   - sol = 101 -> flag stays 1;
   - sol = 100 -> flag clears;
   - sol = 103 -> flag stays 0;
   - sol = 104 -> flag sets.
5. SENSOR_TIMEOUT_EN, adc_done withheld 255 cycles in WAIT_SOL -> sensor_fault = 1, no valid, outputs held; next complete block -> valid = 1, sensor_fault = 0.
6. rst asserted in WAIT_SOL of the 3rd pair -> reset values restored; next valid only after 4 fresh pairs, and its average excludes the pre-reset samples.
